// File: rtl/des_job_sequencer.sv
// Host-side job sequencer for the iterative DES core: key register, block
// issue, bounded wait with error retry and timeout, and result hand-back.
module des_job_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [63:0] key_in,
  output logic        key_ack,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_err,
  output logic        busy,
  output logic        core_start,
  output logic        core_key_ready,
  output logic        core_data_ready,
  output logic [63:0] core_key,
  output logic [63:0] core_data,
  output logic        core_decrypt,
  input  logic        core_done,
  input  logic        core_error,
  input  logic [63:0] core_result
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RECOVER = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  logic [2:0]  state_q, state_d;
  logic [63:0] key_q, key_d;
  logic        key_valid_q, key_valid_d;
  logic        key_ack_q, key_ack_d;
  logic [63:0] data_q, data_d;
  logic        dec_q, dec_d;
  logic [1:0]  retry_q, retry_d;
  logic [7:0]  timer_q, timer_d;
  logic [63:0] res_q, res_d;
  logic        err_q, err_d;

  assign in_ready        = (state_q == S_IDLE) && key_valid_q;
  assign out_valid       = (state_q == S_HOLD);
  assign busy            = (state_q != S_IDLE);
  assign core_start      = (state_q == S_ISSUE) ||
                           (state_q == S_RECOVER);
  assign core_data_ready = core_start;
  assign core_key_ready  = key_valid_q;
  assign core_key        = key_q;
  assign core_data       = data_q;
  assign core_decrypt    = dec_q;
  assign key_ack         = key_ack_q;
  assign out_data        = res_q;
  assign out_err         = err_q;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    key_ack_d   = 1'b0;
    data_d      = data_q;
    dec_d       = dec_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    res_d       = res_q;
    err_d       = err_q;

    // A key written alongside an accept is the one the job runs with
    if (key_load &&
        (state_q == S_IDLE || state_q == S_HOLD)) begin
      key_d       = key_in;
      key_valid_d = 1'b1;
      key_ack_d   = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          dec_d   = in_decrypt;
          retry_d = 2'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (core_done) begin
          res_d   = core_result;
          err_d   = 1'b0;
          state_d = S_HOLD;
        end else if (core_error && retry_q < RETRY_MAX) begin
          retry_d = retry_q + 2'd1;
          state_d = S_RECOVER;
        end else if (core_error || timer_q == TMO_LAST) begin
          res_d   = 64'd0;
          err_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_RECOVER: begin
        state_d = S_ISSUE;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= 64'd0;
      key_valid_q <= 1'b0;
      key_ack_q   <= 1'b0;
      data_q      <= 64'd0;
      dec_q       <= 1'b0;
      retry_q     <= 2'd0;
      timer_q     <= 8'd0;
      res_q       <= 64'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_ack_q   <= key_ack_d;
      data_q      <= data_d;
      dec_q       <= dec_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      res_q       <= res_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_des_job_sequencer.sv
// Directed bench for des_job_sequencer with a small behavioural DES core
// that answers start pulses with done, error, both, or silence.
module tb_des_job_sequencer;

  logic        clk, rst;
  logic        key_load;
  logic [63:0] key_in;
  logic        key_ack;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic        in_decrypt;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic        out_err, busy;
  logic        core_start, core_key_ready, core_data_ready;
  logic [63:0] core_key, core_data;
  logic        core_decrypt;
  logic        core_done, core_error;
  logic [63:0] core_result;

  des_job_sequencer #(
    .TIMEOUT_CYCLES(32),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_load(key_load),
    .key_in(key_in),
    .key_ack(key_ack),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_decrypt(in_decrypt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_err(out_err),
    .busy(busy),
    .core_start(core_start),
    .core_key_ready(core_key_ready),
    .core_data_ready(core_data_ready),
    .core_key(core_key),
    .core_data(core_data),
    .core_decrypt(core_decrypt),
    .core_done(core_done),
    .core_error(core_error),
    .core_result(core_result)
  );

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] K3 = 64'h0011_2233_4455_6677;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: done 18 cycles after start, error after 5 when armed
  int          errs_cfg, err_base, nerr, starts;
  logic        silent, both;
  logic [63:0] res_val;
  logic [5:0]  cnt;
  logic        err_fire;

  assign err_fire    = (cnt == 6'd5) && ((nerr - err_base) < errs_cfg);
  assign core_error  = err_fire || (both && cnt == 6'd18);
  assign core_done   = !silent && cnt == 6'd18;
  assign core_result = res_val;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 6'd0;
    end else if (core_start) begin
      cnt <= 6'd1;
    end else if (err_fire) begin
      cnt  <= 6'd0;
      nerr <= nerr + 1;
    end else if (cnt != 6'd0 && cnt < 6'd40) begin
      cnt <= cnt + 6'd1;
    end
  end

  always @(posedge clk) begin
    if (core_start) starts <= starts + 1;
  end

  int errs, checks;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_job(input logic [63:0] blk,
                         input logic dec,
                         output int lat);
    in_data    = blk;
    in_decrypt = dec;
    in_valid   = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic arm(input int e, input logic s,
                     input logic b, input logic [63:0] r);
    errs_cfg = e;
    err_base = nerr;
    silent   = s;
    both     = b;
    res_val  = r;
  endtask

  int   lat, s0;
  logic seen, stable;

  initial begin
    errs = 0; checks = 0;
    nerr = 0; starts = 0;
    rst = 1'b1;
    key_load = 1'b0; key_in = '0;
    in_valid = 1'b0; in_data = '0; in_decrypt = 1'b0;
    out_ready = 1'b0;
    arm(0, 1'b0, 1'b0, C1);
    tick(); tick();

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_core_key", core_key, 64'd0);
    check("rst_flags",
          64'({in_ready, out_valid, key_ack, core_start,
               core_data_ready, core_key_ready, out_err}), 64'd0);
    rst = 1'b0;
    tick();

    // No key loaded: block must not be taken
    in_data = P1; in_decrypt = 1'b0; in_valid = 1'b1;
    s0 = starts; seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= in_ready;
    end
    check("nokey_in_ready", 64'(seen), 64'd0);
    check("nokey_starts", 64'(starts - s0), 64'd0);

    key_load = 1'b1; key_in = K1;
    check("key_ack_early", 64'(key_ack), 64'd0);
    tick();
    key_load = 1'b0;
    check("key_ack", 64'(key_ack), 64'd1);
    check("core_key", core_key, K1);

    s0 = starts;
    run_job(P1, 1'b0, lat);
    check("job1_lat", 64'(lat), 64'd20);
    check("job1_data", out_data, C1);
    check("job1_err", 64'(out_err), 64'd0);
    check("job1_starts", 64'(starts - s0), 64'd1);
    check("job1_core_data", core_data, P1);
    check("job1_key_ack_low", 64'(key_ack), 64'd0);
    release_out();
    check("job1_idle", 64'(busy), 64'd0);

    // Two recoverable errors then success
    arm(2, 1'b0, 1'b0, 64'hFEDC_BA98_7654_3210);
    s0 = starts;
    run_job(64'h1111_2222_3333_4444, 1'b1, lat);
    check("retry_lat", 64'(lat), 64'd34);
    check("retry_data", out_data, 64'hFEDC_BA98_7654_3210);
    check("retry_err", 64'(out_err), 64'd0);
    check("retry_starts", 64'(starts - s0 - 1), 64'd4);
    check("retry_dec", 64'(core_decrypt), 64'd1);
    release_out();

    // Silent core: timeout without retry
    arm(0, 1'b1, 1'b0, 64'h5555_5555_5555_5555);
    s0 = starts;
    run_job(64'h9999_8888_7777_6666, 1'b0, lat);
    check("tmo_lat", 64'(lat), 64'd34);
    check("tmo_err", 64'(out_err), 64'd1);
    check("tmo_data", out_data, 64'd0);
    check("tmo_starts", 64'(starts - s0), 64'd1);
    release_out();

    // Done and error together: success wins
    arm(0, 1'b0, 1'b1, 64'hCAFE_F00D_DEAD_BEEF);
    run_job(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, lat);
    check("both_lat", 64'(lat), 64'd20);
    check("both_err", 64'(out_err), 64'd0);
    check("both_data", out_data, 64'hCAFE_F00D_DEAD_BEEF);
    release_out();

    // Three errors exhaust the retries
    arm(3, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0);
    s0 = starts;
    run_job(64'h2222_2222_2222_2222, 1'b0, lat);
    check("exh_lat", 64'(lat), 64'd21);
    check("exh_err", 64'(out_err), 64'd1);
    check("exh_data", out_data, 64'd0);
    check("exh_starts", 64'(starts - s0 - 1), 64'd4);
    release_out();

    // Key load during WAIT is ignored
    arm(0, 1'b0, 1'b0, 64'h0BAD_C0DE_0BAD_C0DE);
    in_data = 64'h3333_4444_5555_6666; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    key_load = 1'b1; key_in = K2;
    tick();
    key_load = 1'b0;
    check("wait_key_ack", 64'(key_ack), 64'd0);
    check("wait_core_key", core_key, K1);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check("bp_valid", 64'(out_valid), 64'd1);

    // Backpressure: result held, no new block taken
    in_valid = 1'b1; in_data = 64'h7777_7777_7777_7777;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_data != 64'h0BAD_C0DE_0BAD_C0DE || in_ready || !out_valid)
        stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);

    key_load = 1'b1; key_in = K2;
    tick();
    key_load = 1'b0;
    check("hold_key_ack", 64'(key_ack), 64'd1);
    check("hold_core_key", core_key, K2);

    // Key load in the same cycle as accept is used by that job
    release_out();
    check("idle_in_ready", 64'(in_ready), 64'd1);
    key_load = 1'b1; key_in = K3;
    tick();
    key_load = 1'b0; in_valid = 1'b0;
    check("same_cyc_start", 64'(core_start), 64'd1);
    check("same_cyc_key", core_key, K3);
    check("same_cyc_data", core_data, 64'h7777_7777_7777_7777);

    tick(); tick(); tick();
    check("mid_wait_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_key", core_key, 64'd0);
    check("arst_data", core_data, 64'd0);
    check("arst_out_data", out_data, 64'd0);
    check("arst_flags",
          64'({in_ready, out_valid, key_ack, core_start,
               core_data_ready, core_key_ready, out_err,
               core_decrypt}), 64'd0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    s0 = starts; seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= in_ready | core_key_ready;
    end
    check("post_rst_nokey", 64'(seen), 64'd0);
    check("post_rst_starts", 64'(starts - s0), 64'd0);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
